reg_dump_unit: RTL and testbench

//  Sequential reader for the 8x16 CPU register file: on start, walks the

---
 rtl/reg_dump_if.sv | 24 ++
 rtl/reg_dump_unit.sv | 63 ++++++
 tb/tb_reg_dump_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_if.sv
// reg_dump_if: start/abort control, register-file read port and beat stream of the dump unit
interface reg_dump_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] rd_reg;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic              done;
   modport master (
      input  start, abort, rd_data, out_ready,
      output rd_reg, out_valid, out_addr, out_data, busy, done
   );
   modport slave (
      output start, abort, rd_data, out_ready,
      input  rd_reg, out_valid, out_addr, out_data, busy, done
   );
endinterface

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the register-file read port and streams (addr, data) beats, then pulses done
module reg_dump_unit #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 16,
   parameter int SKIP_R0  = 0
) (
   input logic         clk,
   input logic         rst,
   reg_dump_if.master  bus
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              w_hs;
   logic              w_last;
   logic              w_abort;
   assign w_hs    = r_valid & bus.out_ready;
   assign w_last  = r_idx == ADDR_W'(NUM_REGS - 1);
   assign w_abort = bus.abort & (r_state != S_IDLE);
   // next state: fetch/present alternate per register; abort from any active state wins
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = (bus.start & ~bus.abort) ? S_FETCH : S_IDLE;
         S_FETCH:   w_next = S_PRESENT;
         S_PRESENT: w_next = w_hs ? (w_last ? S_DONE : S_FETCH) : S_PRESENT;
         default:   w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end
   // state register, walk index and the latched beat (captured once, at the FETCH edge)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_abort) r_valid <= 1'b0;
         else if (r_state == S_IDLE && w_next == S_FETCH) r_idx <= ADDR_W'(SKIP_R0 != 0 ? 1 : 0);
         else if (r_state == S_FETCH) begin
            r_data  <= bus.rd_data;
            r_addr  <= r_idx;
            r_valid <= 1'b1;
         end else if (r_state == S_PRESENT && w_hs) begin
            r_valid <= 1'b0;
            if (!w_last) r_idx <= r_idx + ADDR_W'(1);
         end
      end
   end
   assign bus.rd_reg    = (r_state == S_IDLE) ? '0 : r_idx;
   assign bus.out_valid = r_valid;
   assign bus.out_addr  = r_addr;
   assign bus.out_data  = r_data;
   assign bus.busy      = r_state != S_IDLE;
   assign bus.done      = r_state == S_DONE;
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: table, directed and randomized checks of reg_dump_unit against a beat-list model
module tb_reg_dump_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        ready = 1'b0;
   logic [15:0] regs [8];
   logic [18:0] exp_q [$];
   int          n_tests = 0;
   int          n_fail = 0;
   reg_dump_if #(.ADDR_W(3), .DATA_W(16)) ifa ();
   reg_dump_if #(.ADDR_W(3), .DATA_W(16)) ifb ();
   reg_dump_unit #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .SKIP_R0(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   reg_dump_unit #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .SKIP_R0(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
   always #5 clk = ~clk;
   assign ifa.start     = start & ~sel;
   assign ifb.start     = start & sel;
   assign ifa.abort     = abort & ~sel;
   assign ifb.abort     = abort & sel;
   assign ifa.out_ready = ready;
   assign ifb.out_ready = ready;
   assign ifa.rd_data   = regs[ifa.rd_reg];
   assign ifb.rd_data   = regs[ifb.rd_reg];
   logic        v, bz, dn;
   logic [2:0]  a, rd;
   logic [15:0] d;
   assign v  = sel ? ifb.out_valid : ifa.out_valid;
   assign bz = sel ? ifb.busy      : ifa.busy;
   assign dn = sel ? ifb.done      : ifa.done;
   assign a  = sel ? ifb.out_addr  : ifa.out_addr;
   assign rd = sel ? ifb.rd_reg    : ifa.rd_reg;
   assign d  = sel ? ifb.out_data  : ifa.out_data;

   typedef struct {
      logic        skip;
      logic [15:0] mul;
      int          beats;
      int          last_at;
      int          done_at;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, act, req);
      end
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_valid"}, v, 0);
      chk({n, "_busy"}, bz, 0);
      chk({n, "_done"}, dn, 0);
      chk({n, "_addr"}, a, 0);
      chk({n, "_data"}, d, 0);
      chk({n, "_rdreg"}, rd, 0);
   endtask

   task automatic build_exp(input logic s);
      exp_q.delete();
      for (int i = 0; i < 8; i++)
         if (!(s && i == 0)) exp_q.push_back({3'(i), regs[i]});
   endtask

   task automatic run(input logic s, input int pct, input int hold_a,
                      input int w1c, input logic [15:0] w1v, input int w2c, input logic [15:0] w2v,
                      output int beats, output int last_at, output int done_at);
      int          cyc, held;
      logic        pv, pr;
      logic [2:0]  pa;
      logic [15:0] pd;
      sel = s;
      ready = 1'b0;
      start = 1'b1;
      beats = 0; last_at = -1; done_at = -1; held = 0;
      pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
      step();
      start = 1'b0;
      cyc = 1;
      while (cyc < 400 && done_at < 0) begin
         chk("busy_active", bz, 1);
         if (pv && !pr) begin
            chk("hold_valid", v, 1);
            chk("hold_beat", {a, d}, {pa, pd});
         end
         if (w1c == cyc) regs[5] = w1v;
         if (w2c == cyc) regs[5] = w2v;
         ready = ($urandom_range(99) < pct);
         if (v && hold_a == int'(a) && held < 5) begin
            ready = 1'b0;
            held++;
         end
         if (v && ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_beat: got addr %0d data %0h expected no beat", a, d);
            end else chk("beat", {a, d}, exp_q.pop_front());
            beats++;
            last_at = cyc;
         end
         if (dn) begin
            done_at = cyc;
            chk("done_no_valid", v, 0);
         end
         pv = v; pr = ready; pa = a; pd = d;
         step();
         cyc++;
      end
      ready = 1'b0;
      if (done_at < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done within 400 cycles expected done");
      end
      chk("beats_missing", exp_q.size(), 0);
      chk("after_busy", bz, 0);
      chk("after_done", dn, 0);
      chk("after_valid", v, 0);
   endtask

   initial begin
      vec_t vecs [4];
      int   beats, last_at, done_at, t;
      logic s;
      vecs[0] = '{1'b0, 16'h1111, 8, 16, 17};
      vecs[1] = '{1'b1, 16'h1111, 7, 14, 15};
      vecs[2] = '{1'b0, 16'h0101, 8, 16, 17};
      vecs[3] = '{1'b1, 16'h0F0F, 7, 14, 15};
      for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
      step();
      step();
      sel = 1'b0; #1;
      chk_zero("por_a");
      sel = 1'b1; #1;
      chk_zero("por_b");
      sel = 1'b0;
      rst = 1'b0;
      step();

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) regs[i] = 16'(i * vecs[k].mul);
         build_exp(vecs[k].skip);
         run(vecs[k].skip, 100, -1, -1, 16'h0, -1, 16'h0, beats, last_at, done_at);
         chk("tbl_beats", beats, vecs[k].beats);
         chk("tbl_last_at", last_at, vecs[k].last_at);
         chk("tbl_done_at", done_at, vecs[k].done_at);
      end

      for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
      sel = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      step();
      chk_zero("rst1");
      step();
      chk_zero("rst2");
      rst = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_busy", bz, 0);
         chk("post_rst_done", dn, 0);
      end

      build_exp(1'b0);
      run(1'b0, 100, 3, -1, 16'h0, -1, 16'h0, beats, last_at, done_at);
      chk("bp_beats", beats, 8);
      chk("bp_done_at", done_at, 22);

      sel = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      ready = 1'b1;
      t = 0;
      while (!(v && a == 3'd2) && t < 50) begin step(); t++; end
      chk("reach_beat2", {v, a}, {1'b1, 3'd2});
      start = 1'b1;
      step();
      start = 1'b0;
      t = 0;
      while (!v && t < 10) begin step(); t++; end
      chk("start_ignored_addr", {v, a}, {1'b1, 3'd3});
      t = 0;
      while (!(v && a == 3'd4) && t < 50) begin step(); t++; end
      chk("reach_beat4", {v, a}, {1'b1, 3'd4});
      ready = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", v, 0);
      chk("abort_busy", bz, 0);
      chk("abort_done", dn, 0);
      chk("abort_addr", a, 4);
      chk("abort_data", d, 16'h4444);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_no_done", dn, 0);
         chk("abort_idle", bz, 0);
      end
      build_exp(1'b0);
      run(1'b0, 100, -1, -1, 16'h0, -1, 16'h0, beats, last_at, done_at);
      chk("restart_beats", beats, 8);

      for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
      build_exp(1'b0);
      exp_q[5] = {3'd5, 16'hBEEF};
      run(1'b0, 100, -1, 10, 16'hBEEF, 12, 16'hCAFE, beats, last_at, done_at);
      chk("wr_beats", beats, 8);

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
         s = 1'($urandom_range(1));
         build_exp(s);
         run(s, $urandom_range(100, 30), -1, -1, 16'h0, -1, 16'h0, beats, last_at, done_at);
         chk("rnd_beats", beats, s ? 7 : 8);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
